// File: rtl/seg_scan_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_display : 4-digit multiplexed 7-segment driver for BCD MM:SS.    |
// | Optional macro SEG_SCAN_BLINK_EN blinks the display once expired.        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module seg_scan_display #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [16:1] timer,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [16:1]   snap_q, snap_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          scan_wrap;
  logic [3:0]    nib;
  logic          expired;
  logic          blank;

  assign expired = start && (snap_q == 16'h0000);

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  // Leaving expiry clears the blink state so the next expiry starts visible.
  always_comb begin
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if (expired) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blank = expired && blink_phase_q;
`else
  localparam int unused_blink_div = BLINK_DIV;
  logic unused_expired;
  assign unused_expired = expired;
  assign blank          = 1'b0;
`endif

  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SW'(1);
    idx_d      = scan_wrap ? idx_q + 2'd1 : idx_q;
    // Snapshot only at the frame boundary so a frame never mixes two values.
    snap_d     = (scan_wrap && (idx_q == 2'd3)) ? timer : snap_q;
  end

  always_comb begin
    case (idx_q)
      2'd0:    nib = snap_q[4:1];
      2'd1:    nib = snap_q[8:5];
      2'd2:    nib = snap_q[12:9];
      default: nib = snap_q[16:13];
    endcase
  end

  always_comb begin
    case (nib)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b0111111;
    endcase
  end

  always_comb begin
    an_d        = 4'b1111;
    an_d[idx_q] = 1'b0;
    if (blank) begin
      an_d = 4'b1111;
    end
    dp_d = (idx_q != 2'd2) || blank;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
      snap_q     <= 16'h0000;
      an_q       <= 4'b1111;
      seg_q      <= 7'b1111111;
      dp_q       <= 1'b1;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg_scan_display : self-checking bench, SCAN_DIV=4, BLINK_DIV=8.       |
// | Honours SEG_SCAN_BLINK_EN in the reference model.                         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_seg_scan_display;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;
  localparam int FRAME     = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [16:1] timer = 16'h0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int failures = 0;

  // Reference model state: edges since reset release, displayed value, expiry run length.
  int          n = 0;
  logic [16:1] snap_m = 16'h0000;
  int          run = 0;
  logic [6:0]  seg_tab [16];

  seg_scan_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .timer(timer),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check3(input string tag, input logic [3:0] ea,
                        input logic [6:0] es, input logic ed);
    checks++;
    assert (an === ea) else begin
      failures++;
      $error("FAIL %s.an n=%0d observed=%b expected=%b", tag, n, an, ea);
    end
    checks++;
    assert (seg === es) else begin
      failures++;
      $error("FAIL %s.seg n=%0d observed=%b expected=%b", tag, n, seg, es);
    end
    checks++;
    assert (dp === ed) else begin
      failures++;
      $error("FAIL %s.dp n=%0d observed=%b expected=%b", tag, n, dp, ed);
    end
  endtask

  task automatic tick(input string tag);
    int         idx;
    logic       exp_pre;
    logic       blank;
    logic [3:0] nib;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    @(posedge clk);
    n++;
    idx     = ((n - 1) / SCAN_DIV) % 4;
    exp_pre = start && (snap_m == 16'h0000);
    blank   = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
    blank = exp_pre && (((run / BLINK_DIV) % 2) == 1);
    run   = exp_pre ? run + 1 : 0;
`endif
    nib = snap_m[idx*4+1 +: 4];
    ea  = blank ? 4'b1111 : ~(4'b0001 << idx);
    es  = seg_tab[nib];
    ed  = blank ? 1'b1 : (idx != 2);
    if ((n % FRAME) == 0) snap_m = timer;
    #1;
    check3(tag, ea, es, ed);
  endtask

  task automatic ticks(input string tag, input int cnt);
    for (int i = 0; i < cnt; i++) tick(tag);
  endtask

  task automatic reset_model();
    n = 0;
    snap_m = 16'h0000;
    run = 0;
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    // Asynchronous reset at start, held across a few edges.
    #1 rst = 1'b1;
    #2 check3("rst_async", 4'b1111, 7'b1111111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check3("rst_hold", 4'b1111, 7'b1111111, 1'b1);
    end

    // Frame 1 shows zeros, frame 2 shows 1234.
    timer = 16'h1234;
    rst = 1'b0;
    reset_model();
    tick("first_edge");
    checks++;
    assert (an === 4'b1110 && seg === 7'b1000000) else begin
      failures++;
      $error("FAIL first_edge_abs observed=%b/%b expected=1110/1000000", an, seg);
    end
    ticks("frame_1234", 2 * FRAME + 7);

    // Change timer mid-frame; the rest of the frame must still show 1234.
    timer = 16'h5678;
    ticks("midframe_5678", 2 * FRAME);

    timer = 16'h0A0F;
    ticks("dash_0A0F", 2 * FRAME + 3);

    // Expiry: start high with timer zero.
    start = 1'b1;
    timer = 16'h0000;
    ticks("expired", 5 * FRAME);
    start = 1'b0;
    ticks("stopped", FRAME + 5);
    start = 1'b1;
    ticks("reexpired", 3 * FRAME);

    // Randomized timer/start activity.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        timer = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 15) == 0) start = ~start;
      tick("random");
    end

    // Reset asserted mid-cycle while digit 2 is being displayed.
    for (int i = 0; i < FRAME && (((n / SCAN_DIV) % 4) != 2 || (n % SCAN_DIV) == 0); i++)
      tick("seek_idx2");
    tick("at_idx2");
    #2 rst = 1'b1;
    #1 check3("rst_mid_idx2", 4'b1111, 7'b1111111, 1'b1);
    @(posedge clk); #1;
    check3("rst_mid_hold", 4'b1111, 7'b1111111, 1'b1);
    timer = 16'h9087;
    start = 1'b0;
    rst = 1'b0;
    reset_model();
    ticks("after_rst", 2 * FRAME + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
